// File: rtl/wb_port_arbiter_3_if.sv
// ============================================================================
// Module : wb_port_arbiter_3_if
// Desc   : Requester/writeback bundle for the three-input write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_3_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       req;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output req, in_0, in_1, in_2, out_ready,
    input  gnt, sel, out_data, out_valid
  );

  modport slave (
    input  req, in_0, in_1, in_2, out_ready,
    output gnt, sel, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_3.sv
// ============================================================================
// Module : wb_port_arbiter_3
// Desc   : Round-robin arbiter steering one of three 32-bit words per cycle
//          into a one-entry valid/ready output register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_3_to_1_32_bit (
  input  wire logic [1:0]  sel_i,
  input  wire logic [31:0] in_0_i,
  input  wire logic [31:0] in_1_i,
  input  wire logic [31:0] in_2_i,
  output logic      [31:0] out_o
);
  always_comb begin
    out_o = 32'h0;
    case (sel_i)
      2'd0:    out_o = in_0_i;
      2'd1:    out_o = in_1_i;
      2'd2:    out_o = in_2_i;
      default: out_o = 32'h0;
    endcase
  end
endmodule

module wb_port_arbiter_3 #(
  parameter int WIDTH = 32
) (
  input wire logic              clk,
  input wire logic              rst,
  wb_port_arbiter_3_if.slave    bus
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [1:0] SEL_NONE = 2'b11;

  logic [0:0]  state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] out_data_q, out_data_d;

  logic        valid_w;
  logic        acc_w;
  logic        drain_w;
  logic [1:0]  ord0_w, ord1_w, ord2_w;
  logic [1:0]  winner_w;
  logic [1:0]  mux_sel_w;
  logic [31:0] mux_out_w;

  assign valid_w = (state_q == ST_FULL);
  assign acc_w   = (|bus.req) && (!valid_w || bus.out_ready);
  assign drain_w = valid_w && bus.out_ready;

  // Search order starts one past the last winner and wraps mod 3.
  always_comb begin
    ord0_w = 2'd0;
    ord1_w = 2'd1;
    ord2_w = 2'd2;
    case (last_q)
      2'd0: begin ord0_w = 2'd1; ord1_w = 2'd2; ord2_w = 2'd0; end
      2'd1: begin ord0_w = 2'd2; ord1_w = 2'd0; ord2_w = 2'd1; end
      default: begin ord0_w = 2'd0; ord1_w = 2'd1; ord2_w = 2'd2; end
    endcase
  end

  always_comb begin
    winner_w = ord2_w;
    if (bus.req[ord0_w])      winner_w = ord0_w;
    else if (bus.req[ord1_w]) winner_w = ord1_w;
  end

  assign mux_sel_w = acc_w ? winner_w : SEL_NONE;

  mux_3_to_1_32_bit u_mux (
    .sel_i  (mux_sel_w),
    .in_0_i (bus.in_0),
    .in_1_i (bus.in_1),
    .in_2_i (bus.in_2),
    .out_o  (mux_out_w)
  );

  // Grant is masked by reset so no requester believes it was served.
  always_comb begin
    bus.gnt = 3'b000;
    if (!rst && acc_w) begin
      bus.gnt[winner_w] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    if (acc_w) begin
      state_d    = ST_FULL;
      last_d     = winner_w;
      sel_d      = winner_w;
      out_data_d = mux_out_w;
    end else if (drain_w) begin
      state_d = ST_EMPTY;
      sel_d   = SEL_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      last_q     <= 2'd2;
      sel_q      <= SEL_NONE;
      out_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = valid_w;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter_3.sv
// ============================================================================
// Module : tb_wb_port_arbiter_3
// Desc   : Directed self-checking bench for wb_port_arbiter_3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter_3;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_port_arbiter_3_if #(.WIDTH(32)) bus ();

  wb_port_arbiter_3 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset asserted mid-cycle with every requester active.
    rst           = 1'b1;
    bus.req       = 3'b111;
    bus.in_0      = 32'd1;
    bus.in_1      = 32'd2;
    bus.in_2      = 32'd3;
    bus.out_ready = 1'b1;
    #2;
    check("rst_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_sel",   {30'h0, bus.sel},       32'd3);
    check("rst_data",  bus.out_data,           32'h0);
    check("rst_gnt",   {29'h0, bus.gnt},       32'd0);
    tick();
    rst = 1'b0;

    // Round robin: pointer starts at 2, so order is 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), {29'h0, bus.gnt}, 32'd1 << (k % 3));
      tick();
      check($sformatf("rr_data%0d", k), bus.out_data, (k % 3) + 1);
      check($sformatf("rr_sel%0d", k), {30'h0, bus.sel}, k % 3);
      check($sformatf("rr_valid%0d", k), {31'h0, bus.out_valid}, 32'd1);
    end
    bus.req = 3'b000;
    #1;
    check("rr_idle_gnt", {29'h0, bus.gnt}, 32'd0);
    tick();
    check("rr_drain_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rr_drain_sel",   {30'h0, bus.sel},       32'd3);

    // Backpressure: last=2, so requester 0 wins into the empty register.
    bus.req       = 3'b101;
    bus.in_0      = 32'hA0A0_A0A0;
    bus.in_2      = 32'hB2B2_B2B2;
    bus.out_ready = 1'b0;
    #1;
    check("bp_gnt0", {29'h0, bus.gnt}, 32'b001);
    tick();
    bus.req = 3'b100;
    check("bp_data0", bus.out_data, 32'hA0A0_A0A0);
    check("bp_sel0",  {30'h0, bus.sel}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("bp_stall_gnt%0d", k), {29'h0, bus.gnt}, 32'd0);
      tick();
      check($sformatf("bp_stall_data%0d", k), bus.out_data, 32'hA0A0_A0A0);
      check($sformatf("bp_stall_sel%0d", k), {30'h0, bus.sel}, 32'd0);
      check($sformatf("bp_stall_valid%0d", k), {31'h0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_gnt2", {29'h0, bus.gnt}, 32'b100);
    tick();
    bus.req = 3'b000;
    check("bp_data2", bus.out_data, 32'hB2B2_B2B2);
    check("bp_sel2",  {30'h0, bus.sel}, 32'd2);

    // Single requester refilling a draining register (no bubble).
    bus.req  = 3'b010;
    bus.in_1 = 32'hCCCC_CCCC;
    #1;
    check("single_gnt", {29'h0, bus.gnt}, 32'b010);
    tick();
    bus.req = 3'b000;
    check("single_valid", {31'h0, bus.out_valid}, 32'd1);
    check("single_data",  bus.out_data,           32'hCCCC_CCCC);
    check("single_sel",   {30'h0, bus.sel},       32'd1);

    // Load DDDD_DDDD (last=1, so order 2,0,1 picks 0), then drain to empty.
    bus.req  = 3'b001;
    bus.in_0 = 32'hDDDD_DDDD;
    #1;
    check("drain_gnt", {29'h0, bus.gnt}, 32'b001);
    tick();
    bus.req = 3'b000;
    check("drain_full_data", bus.out_data, 32'hDDDD_DDDD);
    check("drain_full_sel",  {30'h0, bus.sel}, 32'd0);
    tick();
    check("drain_valid", {31'h0, bus.out_valid}, 32'd0);
    check("drain_sel",   {30'h0, bus.sel},       32'd3);

    // Reset mid-stream: fill with requester 1 (last=0 -> order 1,2,0), stall, pulse rst.
    bus.out_ready = 1'b0;
    bus.req       = 3'b110;
    bus.in_1      = 32'h1111_1111;
    bus.in_2      = 32'h2222_2222;
    #1;
    check("mid_fill_gnt", {29'h0, bus.gnt}, 32'b010);
    tick();
    check("mid_full_valid", {31'h0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'd0);
    check("mid_rst_sel",   {30'h0, bus.sel},       32'd3);
    check("mid_rst_data",  bus.out_data,           32'h0);
    check("mid_rst_gnt",   {29'h0, bus.gnt},       32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_post_gnt", {29'h0, bus.gnt}, 32'b010);
    tick();
    check("mid_post_data", bus.out_data, 32'h1111_1111);
    check("mid_post_sel",  {30'h0, bus.sel}, 32'd1);
    bus.req       = 3'b100;
    bus.out_ready = 1'b1;
    #1;
    check("mid_next_gnt", {29'h0, bus.gnt}, 32'b100);
    tick();
    bus.req = 3'b000;
    check("mid_next_data", bus.out_data, 32'h2222_2222);
    check("mid_next_sel",  {30'h0, bus.sel}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
